pipe_hold_ctrl: RTL and testbench
=================================

# pipe_hold_ctrl

Pipeline hold/flush controller for the core front end. It merges stall and redirect requests from the fetch bus, decode (load-use), execute (jump, multi-cycle ops) and the data bus into per-stage hold codes. The PC, `if_id` and `id_ex` pipeline registers consume these codes, and the PC also takes a one-cycle redirect strobe. It also tracks redirects deferred by data-bus stalls, extends flushes over the fetch latency, and watches for bus timeouts.

## Interface
- FLUSH_CYC, 1: cycles `if_id` is flushed per redirect (1..4); covers fetch latency
- TIMEOUT, 255: consecutive bus-wait cycles before the timeout error is raised (1..65535)
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jump_req_i  in  1  execute requests redirect this cycle
- jump_addr_i  in  `inst_addr_bus`  redirect target
- ex_stall_i  in  1  multi-cycle execute op not finished
- load_use_i  in  1  decode detected load-use hazard
- ibus_wait_i  in  1  instruction bus did not return data this cycle
- dbus_wait_i  in  1  data bus access not complete
- err_clr_i  in  1  clears timeout_err_o
- hold_pc_o  out  `holdpip_bus`  hold code for PC register
- hold_ifid_o  out  `holdpip_bus`  hold code for `if_id`
- hold_idex_o  out  `holdpip_bus`  hold code for `id_ex`
- jump_en_o  out  1  PC load strobe
- jump_addr_o  out  `inst_addr_bus`  PC load target
- timeout_err_o  out  1  sticky bus timeout flag

## Operation
- Hold codes are `hold_none`, `hold_wait` and `hold_flush`. `hold_wait` freezes a register. `hold_flush` loads its default value (NOP / zero).
- State: fsm {IDLE, FLUSH}, flush counter (clog2(FLUSH_CYC+1) bits), pending flag plus pending address, and timeout counter (16 bits, saturating).
- Each cycle, exactly one of the priority rules below applies (highest first). Outputs are combinational from inputs and state.
  1. dbus_wait_i: all three outputs `hold_wait`; jump_en_o=0. If jump_req_i=1, then pending<=1 and the pending address<=jump_addr_i (overwrite). The flush counter is frozen.
  2. Redirect (jump_req_i, or pending with no jump_req_i): jump_en_o=1. jump_addr_o=jump_addr_i if jump_req_i=1, else the pending address. The PC code is `hold_none`; `if_id` and `id_ex` get `hold_flush`. Then pending<=0. If FLUSH_CYC>1, go to FLUSH with the counter at FLUSH_CYC-1; otherwise stay in IDLE.
  3. fsm==FLUSH: PC code `hold_none`, `if_id` code `hold_flush`, `id_ex` code `hold_none`. The counter decrements and fsm goes to IDLE when the counter reaches 0.
  4. ex_stall_i: all three outputs `hold_wait`.
  5. load_use_i: PC and `if_id` get `hold_wait`; `id_ex` gets `hold_flush` (inserts a bubble).
  6. ibus_wait_i: PC gets `hold_wait`, `if_id` gets `hold_flush`, `id_ex` gets `hold_none`.
  7. Otherwise all outputs are `hold_none`.
- A new redirect during FLUSH (rule 2 outranks rule 3) restarts the flush count.
- jump_addr_o equals jump_addr_i whenever jump_en_o=0.
- Timeout counter:
  - Increments each cycle (ibus_wait_i | dbus_wait_i)=1 and clears to 0 when both are low.
  - When the counter reaches TIMEOUT, timeout_err_o<=1. The flag stays set until err_clr_i=1.
  - If err_clr_i and the timeout condition occur in the same cycle, set wins.

## Timing
- Reset (async, rst_n=0): fsm=IDLE, counters=0, pending=0, pending address=0, timeout_err_o=0. With all inputs at 0, every hold output is `hold_none` and jump_en_o=0.
- Latency:
  - Hold codes and jump_en_o: 0 cycles from inputs (combinational).
  - timeout_err_o: registered; rises 1 cycle after the wait run reaches TIMEOUT cycles.
- A redirect requested in cycle N with no dbus wait: jump_en_o=1 in N, and `if_id` is flushed in cycles N..N+FLUSH_CYC-1.
- A redirect deferred by dbus_wait_i: it issues in the first cycle dbus_wait_i=0, exactly once.
- Reset mid-FLUSH or with a redirect pending: that state is lost and no redirect is issued after reset.

## Test plan
- Reset, then idle inputs: all hold outputs `hold_none`, jump_en_o=0, timeout_err_o=0.
- FLUSH_CYC=2, jump_req_i=1 with jump_addr_i=0x100 for one cycle:
  - Cycle N: jump_en_o=1, jump_addr_o=0x100, `if_id`=`id_ex`=`hold_flush`.
  - Cycle N+1: `if_id`=`hold_flush`, `id_ex`=`hold_none`.
  - Cycle N+2: all `hold_none`.
- dbus_wait_i high for 3 cycles while a jump to 0x200 pulses in cycle 1, then dbus_wait_i low:
  - All outputs `hold_wait` for the 3 cycles.
  - Cycle 4: jump_en_o=1, jump_addr_o=0x200, `if_id`=`id_ex`=`hold_flush`.
- load_use_i and ibus_wait_i high together: PC=`hold_wait`, `if_id`=`hold_wait`, `id_ex`=`hold_flush`. With ex_stall_i added: all three outputs `hold_wait`.
- TIMEOUT=4, ibus_wait_i held high:
  - timeout_err_o rises one cycle after the 4th wait cycle and stays set after the wait drops.
  - A single err_clr_i pulse clears it.
- FLUSH_CYC=3, a second jump to 0x300 in the cycle after the first:
  - jump_en_o=1 in both cycles; the second redirect carries 0x300.
  - `if_id` is flushed for 3 cycles counted from the second jump.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller for the core front end.
// Merges bus, decode and execute stall/redirect requests into per-stage
// hold codes for PC, if_id and id_ex. It defers redirects that arrive
// while the data bus stalls, stretches if_id flushes over the fetch
// latency, and raises a sticky error when a bus wait runs too long.
// Hold code encoding: 2'b00 = none, 2'b01 = wait (freeze), 2'b10 = flush.
module pipe_hold_ctrl #(
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump_req_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              ex_stall_i,
   input  logic              load_use_i,
   input  logic              ibus_wait_i,
   input  logic              dbus_wait_i,
   input  logic              err_clr_i,
   output logic [1:0]        hold_pc_o,
   output logic [1:0]        hold_ifid_o,
   output logic [1:0]        hold_idex_o,
   output logic              jump_en_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              timeout_err_o
);

   localparam logic [1:0] HOLD_NONE  = 2'b00;
   localparam logic [1:0] HOLD_WAIT  = 2'b01;
   localparam logic [1:0] HOLD_FLUSH = 2'b10;

   localparam int unsigned    CNT_W      = $clog2(FLUSH_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [16:0]    TO_LIMIT   = 17'(TIMEOUT);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                pend_r, pend_s;
   logic [ADDR_W-1:0]   pend_addr_r, pend_addr_s;
   logic [15:0]         to_cnt_r, to_cnt_s;
   logic                err_r, err_s;
   logic                bus_wait_s;
   logic                to_hit_s;

   // Priority arbitration of stall/redirect sources into hold codes and next control state.
   always_comb begin
      hold_pc_o   = HOLD_NONE;
      hold_ifid_o = HOLD_NONE;
      hold_idex_o = HOLD_NONE;
      jump_en_o   = 1'b0;
      jump_addr_o = jump_addr_i;
      state_s     = state_r;
      cnt_s       = cnt_r;
      pend_s      = pend_r;
      pend_addr_s = pend_addr_r;
      if (dbus_wait_i) begin
         // Whole front end freezes; a redirect is parked until the bus frees up.
         hold_pc_o   = HOLD_WAIT;
         hold_ifid_o = HOLD_WAIT;
         hold_idex_o = HOLD_WAIT;
         if (jump_req_i) begin
            pend_s      = 1'b1;
            pend_addr_s = jump_addr_i;
         end else begin
            pend_s      = pend_r;
         end
      end else if (jump_req_i || pend_r) begin
         jump_en_o   = 1'b1;
         jump_addr_o = jump_req_i ? jump_addr_i : pend_addr_r;
         hold_ifid_o = HOLD_FLUSH;
         hold_idex_o = HOLD_FLUSH;
         pend_s      = 1'b0;
         if (FLUSH_CYC > 1) begin
            state_s = ST_FLUSH;
            cnt_s   = CNT_RELOAD;
         end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      end else if (state_r == ST_FLUSH) begin
         // Keep discarding fetches still in flight from the old path.
         hold_ifid_o = HOLD_FLUSH;
         cnt_s       = cnt_r - CNT_W'(1);
         if (cnt_s == CNT_ZERO) begin
            state_s = ST_IDLE;
         end else begin
            state_s = ST_FLUSH;
         end
      end else if (ex_stall_i) begin
         hold_pc_o   = HOLD_WAIT;
         hold_ifid_o = HOLD_WAIT;
         hold_idex_o = HOLD_WAIT;
      end else if (load_use_i) begin
         hold_pc_o   = HOLD_WAIT;
         hold_ifid_o = HOLD_WAIT;
         hold_idex_o = HOLD_FLUSH;
      end else if (ibus_wait_i) begin
         hold_pc_o   = HOLD_WAIT;
         hold_ifid_o = HOLD_FLUSH;
      end else begin
         hold_pc_o   = HOLD_NONE;
      end
   end

   // Bus-wait run length (saturating) and sticky timeout flag, set beating clear.
   always_comb begin
      bus_wait_s = ibus_wait_i | dbus_wait_i;
      to_hit_s   = bus_wait_s && (({1'b0, to_cnt_r} + 17'd1) == TO_LIMIT);
      if (!bus_wait_s) begin
         to_cnt_s = 16'd0;
      end else if (to_cnt_r == 16'hFFFF) begin
         to_cnt_s = to_cnt_r;
      end else begin
         to_cnt_s = to_cnt_r + 16'd1;
      end
      if (to_hit_s) begin
         err_s = 1'b1;
      end else if (err_clr_i) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // State, counters, pending redirect and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         pend_r      <= 1'b0;
         pend_addr_r <= {ADDR_W{1'b0}};
         to_cnt_r    <= 16'd0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         pend_r      <= pend_s;
         pend_addr_r <= pend_addr_s;
         to_cnt_r    <= to_cnt_s;
         err_r       <= err_s;
      end
   end

   assign timeout_err_o = err_r;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: three instances (FLUSH_CYC 1/2/3) share inputs
// and are compared every cycle against a rule-level reference model,
// plus directed checks for the documented scenarios.
module tb_pipe_hold_ctrl;

   localparam logic [1:0] H_NONE  = 2'b00;
   localparam logic [1:0] H_WAIT  = 2'b01;
   localparam logic [1:0] H_FLUSH = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jreq, ex, lu, ib, db, clr;
   logic [31:0] jaddr;

   logic [1:0]  hpc [3];
   logic [1:0]  hifid [3];
   logic [1:0]  hidex [3];
   logic        jen [3];
   logic [31:0] jad [3];
   logic        terr [3];

   int total = 0;
   int bad   = 0;

   // reference model state
   int          fc [3]       = '{1, 2, 3};
   int          tmo [3]      = '{6, 4, 4};
   int          flush_left [3];
   bit          pend [3];
   logic [31:0] paddr [3];
   int          run [3];
   bit          err [3];

   always #5 clk = ~clk;

   pipe_hold_ctrl #(.FLUSH_CYC(1), .TIMEOUT(6), .ADDR_W(32)) u_fc1 (
      .clk(clk), .rst_n(rst_n), .jump_req_i(jreq), .jump_addr_i(jaddr),
      .ex_stall_i(ex), .load_use_i(lu), .ibus_wait_i(ib), .dbus_wait_i(db),
      .err_clr_i(clr), .hold_pc_o(hpc[0]), .hold_ifid_o(hifid[0]),
      .hold_idex_o(hidex[0]), .jump_en_o(jen[0]), .jump_addr_o(jad[0]),
      .timeout_err_o(terr[0]));

   pipe_hold_ctrl #(.FLUSH_CYC(2), .TIMEOUT(4), .ADDR_W(32)) u_fc2 (
      .clk(clk), .rst_n(rst_n), .jump_req_i(jreq), .jump_addr_i(jaddr),
      .ex_stall_i(ex), .load_use_i(lu), .ibus_wait_i(ib), .dbus_wait_i(db),
      .err_clr_i(clr), .hold_pc_o(hpc[1]), .hold_ifid_o(hifid[1]),
      .hold_idex_o(hidex[1]), .jump_en_o(jen[1]), .jump_addr_o(jad[1]),
      .timeout_err_o(terr[1]));

   pipe_hold_ctrl #(.FLUSH_CYC(3), .TIMEOUT(4), .ADDR_W(32)) u_fc3 (
      .clk(clk), .rst_n(rst_n), .jump_req_i(jreq), .jump_addr_i(jaddr),
      .ex_stall_i(ex), .load_use_i(lu), .ibus_wait_i(ib), .dbus_wait_i(db),
      .err_clr_i(clr), .hold_pc_o(hpc[2]), .hold_ifid_o(hifid[2]),
      .hold_idex_o(hidex[2]), .jump_en_o(jen[2]), .jump_addr_o(jad[2]),
      .timeout_err_o(terr[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         flush_left[i] = 0; pend[i] = 1'b0; paddr[i] = 32'd0; run[i] = 0; err[i] = 1'b0;
      end
   endtask

   // Expected combinational outputs from the priority rules.
   task automatic model_eval(input int i, output logic [1:0] pc, output logic [1:0] ifid,
                             output logic [1:0] idex, output logic en, output logic [31:0] ja);
      pc = H_NONE; ifid = H_NONE; idex = H_NONE; en = 1'b0; ja = jaddr;
      if (db) begin
         pc = H_WAIT; ifid = H_WAIT; idex = H_WAIT;
      end else if (jreq || pend[i]) begin
         en = 1'b1; ja = jreq ? jaddr : paddr[i]; ifid = H_FLUSH; idex = H_FLUSH;
      end else if (flush_left[i] > 0) begin
         ifid = H_FLUSH;
      end else if (ex) begin
         pc = H_WAIT; ifid = H_WAIT; idex = H_WAIT;
      end else if (lu) begin
         pc = H_WAIT; ifid = H_WAIT; idex = H_FLUSH;
      end else if (ib) begin
         pc = H_WAIT; ifid = H_FLUSH;
      end
   endtask

   task automatic model_step(input int i);
      if (db) begin
         if (jreq) begin pend[i] = 1'b1; paddr[i] = jaddr; end
      end else if (jreq || pend[i]) begin
         pend[i] = 1'b0; flush_left[i] = fc[i] - 1;
      end else if (flush_left[i] > 0) begin
         flush_left[i] = flush_left[i] - 1;
      end
      if (ib || db) begin
         if (run[i] + 1 == tmo[i]) err[i] = 1'b1;
         else if (clr) err[i] = 1'b0;
         if (run[i] < 65535) run[i] = run[i] + 1;
      end else begin
         run[i] = 0;
         if (clr) err[i] = 1'b0;
      end
   endtask

   task automatic drive(input logic j, input logic [31:0] a, input logic e, input logic l,
                        input logic i_w, input logic d_w, input logic c);
      jreq = j; jaddr = a; ex = e; lu = l; ib = i_w; db = d_w; clr = c;
   endtask

   // Compare all instances with the model mid-cycle, then advance one clock.
   task automatic tick();
      logic [1:0] pc, ifid, idex; logic en; logic [31:0] ja;
      #4;
      for (int i = 0; i < 3; i++) begin
         model_eval(i, pc, ifid, idex, en, ja);
         chk($sformatf("fc%0d_pc", fc[i]), 64'(hpc[i]), 64'(pc));
         chk($sformatf("fc%0d_ifid", fc[i]), 64'(hifid[i]), 64'(ifid));
         chk($sformatf("fc%0d_idex", fc[i]), 64'(hidex[i]), 64'(idex));
         chk($sformatf("fc%0d_jen", fc[i]), 64'(jen[i]), 64'(en));
         chk($sformatf("fc%0d_jaddr", fc[i]), 64'(jad[i]), 64'(ja));
         chk($sformatf("fc%0d_terr", fc[i]), 64'(terr[i]), 64'(err[i]));
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #12;
      chk("rst_pc", 64'(hpc[1]), 64'(H_NONE));
      chk("rst_jen", 64'(jen[1]), 64'd0);
      chk("rst_terr", 64'(terr[1]), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tick(); tick();

      // FLUSH_CYC=2 redirect to 0x100
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("j100_en", 64'(jen[1]), 64'd1);
      chk("j100_addr", 64'(jad[1]), 64'h100);
      chk("j100_idex", 64'(hidex[1]), 64'(H_FLUSH));
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("j100_n1_ifid", 64'(hifid[1]), 64'(H_FLUSH));
      chk("j100_n1_idex", 64'(hidex[1]), 64'(H_NONE));
      tick(); #1;
      chk("j100_n2_ifid", 64'(hifid[1]), 64'(H_NONE));
      tick(); tick();

      // deferred redirect to 0x200 across a 3-cycle dbus wait
      drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      chk("dwait_jen", 64'(jen[1]), 64'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("defer_en", 64'(jen[1]), 64'd1);
      chk("defer_addr", 64'(jad[1]), 64'h200);
      tick(); #1;
      chk("defer_once", 64'(jen[1]), 64'd0);
      tick(); tick(); tick();

      // load_use + ibus, then ex_stall added
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
      chk("lu_ib_idex", 64'(hidex[1]), 64'(H_FLUSH));
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
      chk("ex_idex", 64'(hidex[1]), 64'(H_WAIT));
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

      // timeout with TIMEOUT=4
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("to_set", 64'(terr[1]), 64'd1);
      tick(); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("to_clr", 64'(terr[1]), 64'd0);
      tick();

      // back-to-back jumps, FLUSH_CYC=3
      drive(1'b1, 32'h250, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("j300_en", 64'(jen[2]), 64'd1);
      chk("j300_addr", 64'(jad[2]), 64'h300);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("j300_f2", 64'(hifid[2]), 64'(H_FLUSH));
      tick(); #1;
      chk("j300_f3", 64'(hifid[2]), 64'(H_FLUSH));
      tick(); #1;
      chk("j300_end", 64'(hifid[2]), 64'(H_NONE));
      tick();

      // reset with a pending redirect and an active flush
      drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      rst_n = 1'b0; #2;
      model_reset();
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("rst_nopend", 64'(jen[1]), 64'd0);
      chk("rst_noflush", 64'(hifid[2]), 64'(H_NONE));
      tick(); tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int mode;
         mode = (n / 300) % 3;
         drive($urandom_range(0, 99) < 15, $urandom(),
               $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
               $urandom_range(0, 99) < (mode == 1 ? 85 : 25),
               $urandom_range(0, 99) < (mode == 2 ? 60 : 15),
               $urandom_range(0, 99) < 8);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
